// File: rtl/el2_ifu_ic_dbg_arb_pkg.sv
// Shared types for the I-cache debug arbiter.
// Array geometry, FSM states and the held request packet.
package el2_ifu_ic_dbg_arb_pkg;

  localparam int ICACHE_INDEX_HI = 12;
  localparam int ICACHE_NUM_WAYS = 2;
  localparam int IC_DW           = 71;
  localparam int IC_TW           = 26;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ISSUE,
    RD_WAIT,
    RESP
  } el2_ic_dbg_state_t;

  typedef struct packed {
    logic                         wr;
    logic                         tag;
    logic [ICACHE_NUM_WAYS-1:0]   way;
    logic [ICACHE_INDEX_HI:3]     addr;
    logic [IC_DW-1:0]             wdata;
  } el2_ic_dbg_req_pkt_t;

endpackage

// File: rtl/el2_ifu_ic_dbg_arb.sv
// Sequences debug reads/writes of the I-cache arrays and
// shares the array read path with fetch under a starvation bound.
module el2_ifu_ic_dbg_arb
  import el2_ifu_ic_dbg_arb_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic                       req_tag,
  input  logic [ICACHE_NUM_WAYS-1:0] req_way,
  input  logic [ICACHE_INDEX_HI:3]   req_addr,
  input  logic [IC_DW-1:0]           req_wdata,
  output logic                       rsp_valid,
  output logic [IC_DW-1:0]           rsp_data,
  input  logic                       fetch_req,
  output logic                       fetch_gnt,
  output logic                       ic_debug_rd_en,
  output logic                       ic_debug_wr_en,
  output logic                       ic_debug_tag_array,
  output logic [ICACHE_NUM_WAYS-1:0] ic_debug_way,
  output logic [ICACHE_INDEX_HI:3]   ic_debug_addr,
  output logic [IC_DW-1:0]           ic_debug_wr_data,
  input  logic [IC_DW-1:0]           ic_debug_rd_data,
  input  logic [IC_TW-1:0]           ictag_debug_rd_data,
  output logic                       busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(RD_LAT + 1);

  el2_ic_dbg_state_t   state_q, state_d;
  el2_ic_dbg_req_pkt_t hold_q, hold_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [LW-1:0]       lat_q, lat_d;
  logic [IC_DW-1:0]    rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      starve_q   <= '0;
      lat_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      starve_q   <= starve_d;
      lat_q      <= lat_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    starve_d       = starve_q;
    lat_d          = lat_q;
    rsp_data_d     = rsp_data_q;
    req_ready      = 1'b0;
    fetch_gnt      = 1'b0;
    ic_debug_rd_en = 1'b0;
    ic_debug_wr_en = 1'b0;
    rsp_valid      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        fetch_gnt = fetch_req;
        if (req_valid) begin
          hold_d.wr    = req_wr;
          hold_d.tag   = req_tag;
          hold_d.way   = req_way;
          hold_d.addr  = req_addr;
          hold_d.wdata = req_wdata;
          starve_d     = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        // Fetch keeps the array until the debug request has starved.
        if (!fetch_req || starve_q == SW'(STARVE_MAX)) begin
          state_d = ISSUE;
        end else begin
          fetch_gnt = 1'b1;
          starve_d  = starve_q + SW'(1);
        end
      end
      ISSUE: begin
        if (hold_q.wr) begin
          ic_debug_wr_en = 1'b1;
          rsp_data_d     = '0;
          state_d        = RESP;
        end else begin
          ic_debug_rd_en = 1'b1;
          lat_d          = LW'(1);
          state_d        = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == LW'(RD_LAT)) begin
          rsp_data_d = hold_q.tag
                     ? {{(IC_DW-IC_TW){1'b0}}, ictag_debug_rd_data}
                     : ic_debug_rd_data;
          state_d    = RESP;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data           = rsp_data_q;
  assign ic_debug_tag_array = hold_q.tag;
  assign ic_debug_way       = hold_q.way;
  assign ic_debug_addr      = hold_q.addr;
  assign ic_debug_wr_data   = hold_q.wdata;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_el2_ifu_ic_dbg_arb.sv
// Directed bench for el2_ifu_ic_dbg_arb.
// Array model returns read data exactly RD_LAT cycles after rd_en.
module tb_el2_ifu_ic_dbg_arb;
  import el2_ifu_ic_dbg_arb_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_l;
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_wr;
  logic                       req_tag;
  logic [ICACHE_NUM_WAYS-1:0] req_way;
  logic [ICACHE_INDEX_HI:3]   req_addr;
  logic [IC_DW-1:0]           req_wdata;
  logic                       rsp_valid;
  logic [IC_DW-1:0]           rsp_data;
  logic                       fetch_req;
  logic                       fetch_gnt;
  logic                       ic_debug_rd_en;
  logic                       ic_debug_wr_en;
  logic                       ic_debug_tag_array;
  logic [ICACHE_NUM_WAYS-1:0] ic_debug_way;
  logic [ICACHE_INDEX_HI:3]   ic_debug_addr;
  logic [IC_DW-1:0]           ic_debug_wr_data;
  logic [IC_DW-1:0]           ic_debug_rd_data;
  logic [IC_TW-1:0]           ictag_debug_rd_data;
  logic                       busy;

  int npass = 0;
  int nchk  = 0;
  int nrsp;

  localparam logic [IC_DW-1:0] ARR_VAL  = 71'h12_3456_789A_BCDE_F012;
  localparam logic [IC_DW-1:0] ARR_JUNK = 71'h7F_DEAD_BEEF_DEAD_BEEF;
  localparam logic [IC_TW-1:0] TAG_VAL  = 26'h2ABCDEF;
  localparam logic [IC_TW-1:0] TAG_JUNK = 26'h1555555;
  localparam logic [IC_DW-1:0] WDATA    = 71'h55_AAAA_5555_AAAA_5555;

  logic [1:0] rd_pipe = '0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_pipe <= {rd_pipe[0], ic_debug_rd_en};

  assign ic_debug_rd_data    = rd_pipe[1] ? ARR_VAL : ARR_JUNK;
  assign ictag_debug_rd_data = rd_pipe[1] ? TAG_VAL : TAG_JUNK;

  el2_ifu_ic_dbg_arb #(.RD_LAT(2), .STARVE_MAX(8)) dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_wr              (req_wr),
    .req_tag             (req_tag),
    .req_way             (req_way),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .fetch_req           (fetch_req),
    .fetch_gnt           (fetch_gnt),
    .ic_debug_rd_en      (ic_debug_rd_en),
    .ic_debug_wr_en      (ic_debug_wr_en),
    .ic_debug_tag_array  (ic_debug_tag_array),
    .ic_debug_way        (ic_debug_way),
    .ic_debug_addr       (ic_debug_addr),
    .ic_debug_wr_data    (ic_debug_wr_data),
    .ic_debug_rd_data    (ic_debug_rd_data),
    .ictag_debug_rd_data (ictag_debug_rd_data),
    .busy                (busy)
  );

  task automatic chk(input string tag,
                     input logic [IC_DW-1:0] obs,
                     input logic [IC_DW-1:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic wr, input logic tg,
                      input logic [ICACHE_NUM_WAYS-1:0] way,
                      input logic [ICACHE_INDEX_HI:3] addr,
                      input logic [IC_DW-1:0] wd);
    req_valid = 1'b1;
    req_wr    = wr;
    req_tag   = tg;
    req_way   = way;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
  endtask

  initial begin
    rst_l     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_tag   = 1'b0;
    req_way   = '0;
    req_addr  = '0;
    req_wdata = '0;
    fetch_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 71'h0);
    chk("rst_rd_en", ic_debug_rd_en, 1'b0);
    chk("rst_gnt_follow1", fetch_gnt, 1'b1);
    fetch_req = 1'b0;
    #1;
    chk("rst_gnt_follow0", fetch_gnt, 1'b0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    send(1'b0, 1'b0, 2'b01, 10'h1A8, '0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("rd_rd_en", ic_debug_rd_en, (c == 2));
      chk("rd_wr_en", ic_debug_wr_en, 1'b0);
      chk("rd_rsp_valid", rsp_valid, (c == 5));
      if (c == 2) begin
        chk("rd_addr", ic_debug_addr, 10'h1A8);
        chk("rd_way", ic_debug_way, 2'b01);
        chk("rd_fetch_gnt", fetch_gnt, 1'b0);
      end
      if (c == 5) chk("rd_data", rsp_data, ARR_VAL);
    end

    send(1'b0, 1'b1, 2'b10, 10'h055, '0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (c <= 5) chk("tag_tag_array", ic_debug_tag_array, 1'b1);
      chk("tag_rsp_valid", rsp_valid, (c == 5));
      if (c == 5) chk("tag_data", rsp_data, 71'h0000_2ABCDEF);
    end

    send(1'b1, 1'b0, 2'b10, 10'h3FF, WDATA);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("wr_wr_en", ic_debug_wr_en, (c == 2));
      chk("wr_rd_en", ic_debug_rd_en, 1'b0);
      chk("wr_rsp_valid", rsp_valid, (c == 3));
      if (c == 2) chk("wr_wdata", ic_debug_wr_data, WDATA);
      if (c == 3) chk("wr_rsp_zero", rsp_data, 71'h0);
    end

    fetch_req = 1'b1;
    send(1'b0, 1'b0, 2'b01, 10'h010, '0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("stv_gnt", fetch_gnt, (c <= 8 || c == 14));
      chk("stv_rd_en", ic_debug_rd_en, (c == 10));
      chk("stv_rsp_valid", rsp_valid, (c == 13));
      if (c == 13) chk("stv_data", rsp_data, ARR_VAL);
    end
    fetch_req = 1'b0;

    nrsp = 0;
    send(1'b1, 1'b0, 2'b01, 10'h020, WDATA);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) req_valid = 1'b0;
      #1;
      if (rsp_valid) nrsp++;
      if (c <= 7) chk("bsy_ready", req_ready, (c == 4));
      chk("bsy_rsp_valid", rsp_valid, (c == 3 || c == 7));
    end
    chk("bsy_rsp_count", nrsp, 2);

    send(1'b0, 1'b0, 2'b10, 10'h2A5, '0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    #1;
    chk("mid_busy_before", busy, 1'b1);
    rst_l = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_way", ic_debug_way, 2'b00);
    chk("mid_addr", ic_debug_addr, 10'h000);
    chk("mid_ready", req_ready, 1'b1);
    nrsp = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) rst_l = 1'b1;
      #1;
      if (rsp_valid) nrsp++;
    end
    chk("mid_no_rsp", nrsp, 0);
    send(1'b0, 1'b0, 2'b01, 10'h1A8, '0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("post_rsp_valid", rsp_valid, (c == 5));
      if (c == 5) chk("post_data", rsp_data, ARR_VAL);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
